// File: rtl/wm_apb_blend_streamer.sv
// APB-programmable multi-channel watermark blender: streams alpha*P + beta*W pixels with valid/ready.
// Optional build macro WM_WHITE_SKIP_EN: a watermark pixel equal to IWHITE passes the primary pixel through.
module wm_apb_blend_streamer #(
  parameter int unsigned Amba_Word       = 16,
  parameter int unsigned Amba_Addr_Depth = 20,
  parameter int unsigned Data_Depth      = 8,
  parameter int unsigned CHANNELS        = 3,
  parameter int unsigned MAX_PIX         = 1024,
  parameter int unsigned FRAC_BITS       = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [Amba_Addr_Depth:0]    PADDR,
  input  logic [Amba_Word-1:0]        PWDATA,
  output logic [Amba_Word-1:0]        PRDATA,
  input  logic                        Pixel_Ready,
  output logic                        new_pixel,
  output logic [Data_Depth-1:0]       Pixel_Data,
  output logic [$clog2(CHANNELS):0]   Pixel_Ch,
  output logic                        Image_Done
);
  localparam int unsigned OFF_W = Amba_Addr_Depth - 1;
  localparam int unsigned DEPTH = CHANNELS * MAX_PIX;
  localparam int unsigned RA_W  = $clog2(DEPTH);
  localparam int unsigned PIX_W = $clog2(MAX_PIX + 1);
  localparam int unsigned CH_W  = $clog2(CHANNELS) + 1;
  localparam int unsigned S_W   = 2 * Data_Depth + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic                  r_err;
  logic                  r_done;
  logic [Amba_Word-1:0]  r_npix;
  logic [Data_Depth-1:0] r_iwhite;
  logic [Data_Depth-1:0] r_alpha [CHANNELS];
  logic [Data_Depth-1:0] r_beta  [CHANNELS];
  logic [Data_Depth-1:0] r_prim  [DEPTH];
  logic [Data_Depth-1:0] r_wm    [DEPTH];
  logic [Amba_Word-1:0]  r_prdata;
  logic [PIX_W-1:0]      r_ip;
  logic [CH_W-1:0]       r_ic;
  logic                  r_s1_v, r_s1_last, r_s2_v, r_s2_last, r_out_v, r_out_last;
  logic [CH_W-1:0]       r_s1_ch, r_s2_ch, r_out_ch;
  logic [Data_Depth-1:0] r_s1_p, r_s1_w, r_s2_y, r_out_y;

  logic [1:0]            w_region;
  logic [OFF_W-1:0]      w_off;
  logic                  w_wr, w_cfg_wr, w_ctrl_wr, w_ram_ok, w_npix_ok;
  logic [RA_W-1:0]       w_ram_a, w_px_a;
  logic [Amba_Word-1:0]  w_reg_rd, w_rd_data;
  logic                  w_stall, w_xfer, w_issue, w_issue_last;
  logic [Data_Depth-1:0] w_a, w_b, w_sat, w_y;
  logic [S_W-1:0]        w_s, w_sh;

  assign w_region  = PADDR[Amba_Addr_Depth -: 2];
  assign w_off     = PADDR[OFF_W-1:0];
  assign w_wr      = PSEL && PENABLE && PWRITE;
  assign w_cfg_wr  = w_wr && (r_state != S_RUN);
  assign w_ctrl_wr = w_wr && (w_region == 2'b00) && (w_off == OFF_W'(0));
  assign w_ram_ok  = w_off < OFF_W'(DEPTH);
  assign w_ram_a   = w_ram_ok ? RA_W'(w_off) : '0;
  assign w_npix_ok = (r_npix != '0) && (r_npix <= Amba_Word'(MAX_PIX));

  assign w_stall      = r_out_v && !Pixel_Ready;
  assign w_xfer       = r_out_v && Pixel_Ready;
  assign w_issue      = (r_state == S_RUN) && (Amba_Word'(r_ip) < r_npix);
  assign w_issue_last = (Amba_Word'(r_ip) + Amba_Word'(1) == r_npix) && (r_ic == CH_W'(CHANNELS - 1));
  assign w_px_a       = w_issue ? RA_W'(RA_W'(r_ic) * RA_W'(MAX_PIX) + RA_W'(r_ip)) : '0;

  // Register file read decode
  always_comb begin
    w_reg_rd = '0;
    if (w_off == OFF_W'(0)) w_reg_rd = Amba_Word'({r_err, r_state == S_DONE, r_state == S_RUN});
    if (w_off == OFF_W'(1)) w_reg_rd = r_npix;
    if (w_off == OFF_W'(2)) w_reg_rd = Amba_Word'(r_iwhite);
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (w_off == OFF_W'(3 + 2 * c)) w_reg_rd = Amba_Word'(r_alpha[c]);
      if (w_off == OFF_W'(4 + 2 * c)) w_reg_rd = Amba_Word'(r_beta[c]);
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_region)
      2'b00:   w_rd_data = w_reg_rd;
      2'b01:   if (w_ram_ok) w_rd_data = Amba_Word'(r_prim[w_ram_a]);
      2'b10:   if (w_ram_ok) w_rd_data = Amba_Word'(r_wm[w_ram_a]);
      default: w_rd_data = '0;
    endcase
  end

  // Blend stage: weighted sum, round half up, saturate
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (r_s1_ch == CH_W'(c)) begin
        w_a = r_alpha[c];
        w_b = r_beta[c];
      end
    end
    w_s   = S_W'(w_a) * S_W'(r_s1_p) + S_W'(w_b) * S_W'(r_s1_w) + (S_W'(1) << (FRAC_BITS - 1));
    w_sh  = w_s >> FRAC_BITS;
    w_sat = (w_sh > S_W'(2 ** Data_Depth - 1)) ? '1 : w_sh[Data_Depth-1:0];
`ifdef WM_WHITE_SKIP_EN
    w_y   = (r_s1_w == r_iwhite) ? r_s1_p : w_sat;
`else
    w_y   = w_sat;
`endif
  end

  // Image storage has no reset
  always_ff @(posedge clk) begin
    if (w_cfg_wr && w_ram_ok && (w_region == 2'b01)) r_prim[w_ram_a] <= PWDATA[Data_Depth-1:0];
    if (w_cfg_wr && w_ram_ok && (w_region == 2'b10)) r_wm[w_ram_a]   <= PWDATA[Data_Depth-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_npix   <= '0;
      r_iwhite <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        r_alpha[c] <= '0;
        r_beta[c]  <= '0;
      end
      r_prdata <= '0;
      r_ip <= '0; r_ic <= '0;
      r_s1_v <= 1'b0; r_s1_last <= 1'b0; r_s1_ch <= '0; r_s1_p <= '0; r_s1_w <= '0;
      r_s2_v <= 1'b0; r_s2_last <= 1'b0; r_s2_ch <= '0; r_s2_y <= '0;
      r_out_v <= 1'b0; r_out_last <= 1'b0; r_out_ch <= '0; r_out_y <= '0;
    end else begin
      if (PSEL && !PENABLE && !PWRITE) r_prdata <= w_rd_data;
      if (w_cfg_wr && (w_region == 2'b00)) begin
        if (w_off == OFF_W'(1)) r_npix   <= PWDATA;
        if (w_off == OFF_W'(2)) r_iwhite <= PWDATA[Data_Depth-1:0];
        for (int c = 0; c < int'(CHANNELS); c++) begin
          if (w_off == OFF_W'(3 + 2 * c)) r_alpha[c] <= PWDATA[Data_Depth-1:0];
          if (w_off == OFF_W'(4 + 2 * c)) r_beta[c]  <= PWDATA[Data_Depth-1:0];
        end
      end
      // Read -> blend -> output, all frozen while the output beat is refused
      if (!w_stall) begin
        r_s1_v     <= w_issue;
        r_s1_last  <= w_issue_last;
        r_s1_ch    <= r_ic;
        r_s1_p     <= r_prim[w_px_a];
        r_s1_w     <= r_wm[w_px_a];
        r_s2_v     <= r_s1_v;
        r_s2_last  <= r_s1_last;
        r_s2_ch    <= r_s1_ch;
        r_s2_y     <= w_y;
        r_out_v    <= r_s2_v;
        r_out_last <= r_s2_last;
        r_out_ch   <= r_s2_ch;
        r_out_y    <= r_s2_y;
        if (w_issue) begin
          if (r_ic == CH_W'(CHANNELS - 1)) begin
            r_ic <= '0;
            r_ip <= r_ip + PIX_W'(1);
          end else begin
            r_ic <= r_ic + CH_W'(1);
          end
        end
      end
      if (w_xfer && r_out_last) begin
        r_state <= S_DONE;
        r_done  <= 1'b1;
      end
      // ABORT wins over START and flushes in-flight beats
      if (w_ctrl_wr) begin
        if (PWDATA[1]) begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_s1_v  <= 1'b0;
          r_s2_v  <= 1'b0;
          r_out_v <= 1'b0;
        end else if (PWDATA[0] && (r_state != S_RUN)) begin
          if (w_npix_ok) begin
            r_state <= S_RUN;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_ip    <= '0;
            r_ic    <= '0;
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign PRDATA     = r_prdata;
  assign new_pixel  = r_out_v;
  assign Pixel_Data = r_out_y;
  assign Pixel_Ch   = r_out_ch;
  assign Image_Done = r_done;

endmodule

// File: tb/tb_wm_apb_blend_streamer.sv
// Randomized scoreboard bench for wm_apb_blend_streamer; expected beats come from an arithmetic blend model.
module tb_wm_apb_blend_streamer;
  localparam int CH   = 3;
  localparam int MAXP = 1024;
  localparam int FRAC = 7;

  logic        clk = 1'b0;
  logic        rst, psel, penable, pwrite, rdy;
  logic [20:0] paddr;
  logic [15:0] pwdata, prdata;
  logic        new_pixel, image_done;
  logic [7:0]  pixel_data;
  logic [2:0]  pixel_ch;

  always #5 clk = ~clk;

  wm_apb_blend_streamer dut (
    .clk(clk), .rst(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .Pixel_Ready(rdy),
    .new_pixel(new_pixel), .Pixel_Data(pixel_data), .Pixel_Ch(pixel_ch), .Image_Done(image_done)
  );

  typedef struct { logic [7:0] d; logic [2:0] ch; } beat_t;
  beat_t q[$];
  int checks = 0, errors = 0, beats = 0, rdy_mode = 0;
  int m_alpha [CH];
  int m_beta  [CH];
  int m_white = 0;
  int m_prim [CH][16];
  int m_wm   [CH][16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int blend(input int a, input int b, input int p, input int w);
    int y;
`ifdef WM_WHITE_SKIP_EN
    if (w == m_white) return p;
`endif
    y = (a * p + b * w + (1 << (FRAC - 1))) / (1 << FRAC);
    return (y > 255) ? 255 : y;
  endfunction

  function automatic logic [20:0] adr(input int r, input int off);
    logic [1:0] rr;
    rr = 2'(r);
    return {rr, 19'(off)};
  endfunction

  task automatic apb_write(input logic [20:0] a, input logic [15:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [20:0] a, output int d);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1 penable = 1; d = int'(prdata);
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  task automatic set_coef(input int c, input int a, input int b);
    apb_write(adr(0, 3 + 2 * c), 16'(a));
    apb_write(adr(0, 4 + 2 * c), 16'(b));
    m_alpha[c] = a; m_beta[c] = b;
  endtask

  task automatic set_white(input int w);
    apb_write(adr(0, 2), 16'(w));
    m_white = w;
  endtask

  task automatic load_px(input int c, input int p, input int pv, input int wv);
    apb_write(adr(1, c * MAXP + p), 16'(pv));
    apb_write(adr(2, c * MAXP + p), 16'(wv));
    m_prim[c][p] = pv; m_wm[c][p] = wv;
  endtask

  task automatic start_img(input int npix);
    beat_t b;
    apb_write(adr(0, 1), 16'(npix));
    for (int p = 0; p < npix; p++)
      for (int c = 0; c < CH; c++) begin
        b.d  = 8'(blend(m_alpha[c], m_beta[c], m_prim[c][p], m_wm[c][p]));
        b.ch = 3'(c);
        q.push_back(b);
      end
    apb_write(adr(0, 0), 16'h1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((q.size() != 0 || !image_done) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, int'(q.size() == 0 && image_done), 1);
    q.delete();
  endtask

  // Backpressure driver
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability and the done edge
  initial begin
    beat_t b;
    logic       prev_stall, pend_done;
    logic [7:0] prev_d;
    logic [2:0] prev_ch;
    prev_stall = 0; pend_done = 0; prev_d = 0; prev_ch = 0;
    forever begin
      @(negedge clk);
      if (pend_done) begin
        chk("image_done_rise", int'(image_done), 1);
        pend_done = 0;
      end
      if (prev_stall && new_pixel) begin
        chk("stall_data", int'(pixel_data), int'(prev_d));
        chk("stall_ch", int'(pixel_ch), int'(prev_ch));
      end
      if (new_pixel && rdy) begin
        beats++;
        chk("done_low_in_stream", int'(image_done), 0);
        chk("beat_expected", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          b = q.pop_front();
          chk("pixel_data", int'(pixel_data), int'(b.d));
          chk("pixel_ch", int'(pixel_ch), int'(b.ch));
          if (q.size() == 0) pend_done = 1;
        end
      end
      prev_stall = new_pixel && !rdy;
      prev_d     = pixel_data;
      prev_ch    = pixel_ch;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, np, target, n;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; rst = 0;
    for (int c = 0; c < CH; c++) begin
      m_alpha[c] = 0; m_beta[c] = 0;
      for (int p = 0; p < 16; p++) begin m_prim[c][p] = 0; m_wm[c][p] = 0; end
    end
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    chk("rst_new_pixel", int'(new_pixel), 0);
    chk("rst_image_done", int'(image_done), 0);
    chk("rst_prdata", int'(prdata), 0);
    apb_read(adr(0, 0), d); chk("rst_ctrl", d, 0);

    // Register readback
    for (int c = 0; c < CH; c++) set_coef(c, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    set_white(int'($urandom_range(0, 255)));
    for (int c = 0; c < CH; c++) begin
      apb_read(adr(0, 3 + 2 * c), d); chk("alpha_rb", d, m_alpha[c]);
      apb_read(adr(0, 4 + 2 * c), d); chk("beta_rb", d, m_beta[c]);
    end
    apb_read(adr(0, 2), d); chk("iwhite_rb", d, m_white);
    apb_read(adr(3, 5), d); chk("region3_rd", d, 0);
    apb_read(adr(1, CH * MAXP), d); chk("ram_oob_rd", d, 0);

    // Pass-through blend with first-beat latency
    set_white(255);
    for (int c = 0; c < CH; c++) set_coef(c, 128, 0);
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < CH; c++) load_px(c, p, int'($urandom_range(0, 254)), int'($urandom_range(0, 254)));
    apb_read(adr(1, 2 * MAXP + 3), d); chk("prim_rb", d, m_prim[2][3]);
    start_img(4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("latency_early", int'(new_pixel), 0);
    @(posedge clk); #1;
    chk("latency_first", int'(new_pixel), 1);
    wait_done("blend_done");
    apb_read(adr(0, 0), d); chk("ctrl_done", d, 2);

    // Rounding and saturation
    for (int c = 0; c < CH; c++) begin set_coef(c, 64, 64); load_px(c, 0, 3, 4); end
    start_img(1); wait_done("round_done");
    for (int c = 0; c < CH; c++) begin set_coef(c, 255, 255); load_px(c, 0, 255, 255); end
    start_img(1); wait_done("sat_done");
    // White watermark pixel
    for (int c = 0; c < CH; c++) begin set_coef(c, 64, 64); load_px(c, 0, 90, 255); end
    start_img(1); wait_done("white_done");

    // Random images under backpressure
    for (int it = 0; it < 3; it++) begin
      rdy_mode = (it == 1) ? 2 : 1;
      np = int'($urandom_range(1, 8));
      for (int c = 0; c < CH; c++) set_coef(c, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      set_white(int'($urandom_range(0, 255)));
      for (int p = 0; p < np; p++)
        for (int c = 0; c < CH; c++)
          load_px(c, p, int'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0) ? m_white : int'($urandom_range(0, 255)));
      start_img(np);
      wait_done("random_done");
    end
    rdy_mode = 0;

    // Error handling
    apb_write(adr(0, 0), 16'h2);
    apb_read(adr(0, 0), d); chk("abort_from_done", d, 0);
    chk("abort_done_low", int'(image_done), 0);
    apb_write(adr(0, 1), 16'h0);
    apb_write(adr(0, 0), 16'h1);
    repeat (6) begin @(posedge clk); #1; end
    chk("npix0_no_pixel", int'(new_pixel), 0);
    apb_read(adr(0, 0), d); chk("npix0_err", d, 4);
    start_img(2); wait_done("after_err_done");
    apb_read(adr(0, 0), d); chk("err_cleared", d, 2);
    apb_write(adr(0, 0), 16'h2);
    apb_write(adr(0, 1), 16'(MAXP + 1));
    apb_write(adr(0, 0), 16'h1);
    repeat (4) begin @(posedge clk); #1; end
    chk("npix_big_no_pixel", int'(new_pixel), 0);
    apb_read(adr(0, 0), d); chk("npix_big_err", d, 4);

    // Writes while busy are ignored
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < CH; c++) load_px(c, p, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    rdy_mode = 1;
    start_img(8);
    apb_write(adr(0, 0), 16'h1);
    apb_write(adr(0, 1), 16'h2);
    apb_write(adr(1, 7), 16'((m_prim[0][7] + 1) % 256));
    apb_read(adr(0, 0), d); chk("ctrl_busy", d, 1);
    wait_done("busy_run_done");
    apb_read(adr(0, 1), d); chk("npix_kept", d, 8);
    rdy_mode = 0;

    // Abort mid-stream
    start_img(4);
    target = beats + 5;
    n = 0;
    while (beats < target && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort_wait", int'(beats >= target), 1);
    apb_write(adr(0, 0), 16'h2);
    chk("abort_new_pixel", int'(new_pixel), 0);
    chk("abort_image_done", int'(image_done), 0);
    q.delete();
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_quiet", int'(new_pixel), 0);
    apb_read(adr(0, 0), d); chk("abort_ctrl", d, 0);

    // Reset mid-stream
    rdy_mode = 1;
    start_img(8);
    repeat (6) begin @(posedge clk); #1; end
    rst = 0;
    #1;
    chk("midrst_new_pixel", int'(new_pixel), 0);
    chk("midrst_image_done", int'(image_done), 0);
    chk("midrst_prdata", int'(prdata), 0);
    q.delete();
    @(posedge clk); #1 rst = 1;
    rdy_mode = 0;
    @(posedge clk); #1;
    apb_read(adr(0, 0), d); chk("midrst_ctrl", d, 0);
    apb_read(adr(0, 3), d); chk("midrst_alpha", d, 0);
    apb_read(adr(0, 1), d); chk("midrst_npix", d, 0);
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_quiet", int'(new_pixel), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
